if_prefetch: RTL

- Instruction fetch front end that sits directly upstream of the decode stage.
- Issues word fetches to a multi-cycle instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle to decode as inst_id / pc_plus_four_id.
- Absorbs decode stalls, and flushes on branch/jump redirects from decode control.

---
 rtl/if_prefetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction fetch front end. Issues single-outstanding word
//                fetches to a multi-cycle instruction memory, buffers returned
//                words in a small prefetch FIFO and presents one instruction
//                per cycle to decode. Absorbs decode stalls and flushes on
//                branch/jump redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0015
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_id,
  output logic [31:0] pc_plus_four_id,
  output logic        inst_valid
);

  localparam int unsigned        c_PTR_W     = $clog2(DEPTH);
  localparam int unsigned        c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH_M1  = c_CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_fetch_pc;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [31:0]          r_fifo_pc   [DEPTH];
  logic [31:0]          r_fifo_inst [DEPTH];

  logic                 w_pop;
  logic                 w_push;
  logic [c_CNT_W-1:0]   w_cnt_after_pop;
  logic                 w_room_after_push;
  logic [31:0]          w_addr_next;

  // A redirect flushes the FIFO, so neither push nor pop may take effect then;
  // an ack that coincides with a redirect belongs to the abandoned path.
  assign w_pop             = !redirect && !stall && (r_count != '0);
  assign w_push            = (r_state == ST_REQ) && imem_ack && !redirect;
  assign w_cnt_after_pop   = r_count - c_CNT_W'(w_pop);
  assign w_room_after_push = (w_cnt_after_pop < c_DEPTH_M1);
  assign w_addr_next       = imem_addr + 32'd4;

  // Prefetch FIFO storage: write the returned word with the address it came from
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= imem_addr;
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // Fetch FSM: one outstanding request, back-to-back issue while FIFO has room
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end else if (w_cnt_after_pop < c_DEPTH) begin
            imem_req  <= 1'b1;
            imem_addr <= r_fetch_pc;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack && redirect) begin
            r_fetch_pc <= redirect_pc;
            imem_req   <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (imem_ack) begin
            r_fetch_pc <= w_addr_next;
            if (w_room_after_push) begin
              imem_addr <= w_addr_next;
            end else begin
              imem_req <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else if (redirect) begin
            // Request stays on the bus until memory answers; the answer is dropped
            r_fetch_pc <= redirect_pc;
            r_state    <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (redirect) r_fetch_pc <= redirect_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Decode register: redirect beats stall, stall holds, otherwise pop or inject NOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_id         <= NOP_INST;
      pc_plus_four_id <= RESET_PC;
      inst_valid      <= 1'b0;
    end else if (redirect) begin
      inst_id         <= NOP_INST;
      pc_plus_four_id <= redirect_pc;
      inst_valid      <= 1'b0;
    end else if (!stall) begin
      if (r_count != '0) begin
        inst_id         <= r_fifo_inst[r_rd_ptr];
        pc_plus_four_id <= r_fifo_pc[r_rd_ptr] + 32'd4;
        inst_valid      <= 1'b1;
      end else begin
        inst_id    <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
